boot_sequencer: RTL
===================

// Module: boot_sequencer
// PURPOSE
//   Loader/run controller for the single-cycle CPU. Takes a valid/ready word stream of header+payload
//   commands, drives the CPU's program-memory and data-memory load ports, then releases cpu_rstn for a
//   bounded number of cycles. Sits between the test/host interface and the CPU top; memories must be
//   reset by the global rstn only, never by cpu_rstn, so loaded contents and results survive runs.
// PARAMETERS
//   BITS      32   data word width (matches CPU BITS; header format below needs BITS=32)
//   PM_DEPTH  256  program memory depth in words
//   DM_DEPTH  256  data memory depth in words
// PORTS
//   clk                    in   1                      single clock, all state on rising edge
//   rstn                   in   1                      asynchronous active-low reset
//   s_valid                in   1                      stream word valid
//   s_ready                out  1                      stream word accepted when s_valid&&s_ready
//   s_data                 in   BITS                   header or payload word
//   stop_req               in   1                      abort current load/run
//   pc                     in   BITS                   CPU program counter (used only with HALT_DETECT_EN)
//   pm_write_en            out  1                      to CPU pm_write_en
//   pm_write_address       out  $clog2(PM_DEPTH)+2     byte address = word index << 2
//   pm_data_in             out  BITS                   program word
//   dm_write_en            out  1                      to CPU dm_write_en
//   dm_write_address_load  out  $clog2(DM_DEPTH)       word address
//   dm_data_in_load        out  BITS                   data word
//   cpu_rstn               out  1                      CPU reset, low except during RUN
//   busy / running         out  1                      not IDLE / in RUN
//   done                   out  1                      1-cycle pulse at end of RUN
//   error                  out  1                      sticky, cleared on next accepted header
//   halted                 out  1                      last RUN ended by halt detection
// BEHAVIOUR
// - Reset: state IDLE; s_ready=1; all write enables, addresses, data, cpu_rstn, busy, running, done,
//   error, halted = 0. Reset mid-load or mid-run takes effect immediately (cpu_rstn low same instant).
// - Header: [31:30] cmd (00 LOAD_PM, 01 LOAD_DM, 10 RUN, 11 reserved), [29:16] start word index,
//   [15:0] count (LOAD) or cycle budget (RUN).
// - FSM IDLE -> LOAD_PM / LOAD_DM / RUN on accepted header; state changes on the accepting edge.
//   LOAD with count=0: no writes, stay IDLE. cmd 11: header consumed, error=1, stay IDLE.
// - LOAD: s_ready=1; each accepted beat produces exactly one registered write pulse the next cycle
//   (1-cycle latency, at most one write per cycle). Gaps in s_valid stall the load, no writes issued.
//   Index increments by 1 per beat, wraps modulo DEPTH. start >= DEPTH: error=1, index = start mod DEPTH.
//   After the count-th beat, return to IDLE (the final write pulse occurs in the IDLE cycle).
// - RUN: s_ready=0; cpu_rstn=1 and running=1 starting the cycle after header acceptance for exactly
//   budget cycles (16-bit down-counter); budget 0 = run until stop_req. At end: cpu_rstn=0, done=1 for
//   one cycle, state IDLE, s_ready=1 the same cycle.
// - stop_req in LOAD: pending write still issued, remaining beats dropped, IDLE, error=1.
//   stop_req in RUN: ends run next edge like budget expiry (done pulses, error unchanged).
//   stop_req in IDLE: ignored. stop_req and last beat/budget expiry same cycle: normal completion wins.
// - pm/dm write enables never both high; write data/address hold their last value when enable is 0.
// CONFIGURATION
//   HALT_DETECT_EN defined: in RUN, if pc equals its value on each of the two previous edges
//   (jump-to-self), end the run as on budget expiry and set halted=1 (cleared on next RUN header).
//   Not defined: pc ignored, halted tied 0, run ends only on budget or stop_req.
// TESTING
//   1. Header 0x0000_0003 + words 11,22,33 -> pm_write_en 3 pulses, addr 0x000/0x004/0x008, data
//      11/22/33, cpu_rstn stays 0, busy low after last.
//   2. Header 0x40FE_0004 (DM, start 254, count 4) -> dm addresses 254,255,0,1; error=0.
//   3. Header 0x8000_000A -> cpu_rstn high exactly 10 cycles, s_ready=0 throughout, done 1 cycle after.
//   4. LOAD_PM count 3 with 2-cycle s_valid gaps between beats -> exactly 3 writes, one per accepted beat.
//   5. stop_req after 1st of 3 DM beats -> 1 write only, IDLE, error=1; next header clears error.
//      Assert rstn low mid-RUN -> cpu_rstn, running 0 asynchronously, no done pulse.
//   6. HALT_DETECT_EN: load "j 0x8" at word 2, RUN budget 0 -> run ends ~3 cycles after pc reaches 8,
//      halted=1, done pulses; macro off -> runs until stop_req, halted=0.

Source files
------------

// File: rtl/boot_sequencer.sv
// Loader/run controller: streams header+payload words into CPU program/data
// memory, then releases cpu_rstn for a bounded run. Optional: HALT_DETECT_EN.
module boot_sequencer #(
    parameter int BITS     = 32,
    parameter int PM_DEPTH = 256,
    parameter int DM_DEPTH = 256
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [BITS-1:0]             s_data,
    input  logic                        stop_req,
    input  logic [BITS-1:0]             pc,
    output logic                        pm_write_en,
    output logic [$clog2(PM_DEPTH)+1:0] pm_write_address,
    output logic [BITS-1:0]             pm_data_in,
    output logic                        dm_write_en,
    output logic [$clog2(DM_DEPTH)-1:0] dm_write_address_load,
    output logic [BITS-1:0]             dm_data_in_load,
    output logic                        cpu_rstn,
    output logic                        busy,
    output logic                        running,
    output logic                        done,
    output logic                        error,
    output logic                        halted
);

    localparam int PAW = $clog2(PM_DEPTH);
    localparam int DAW = $clog2(DM_DEPTH);
    localparam int IW  = (PAW > DAW) ? PAW : DAW;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD_PM = 2'd1,
        LOAD_DM = 2'd2,
        RUN     = 2'd3
    } state_t;

    state_t state;
    state_t state_n;

    logic [1:0]    hdr_cmd;
    logic [13:0]   hdr_start;
    logic [15:0]   hdr_cnt;
    logic [IW-1:0] pm_start;
    logic [IW-1:0] dm_start;
    logic          pm_oob;
    logic          dm_oob;

    logic [IW-1:0] idx;
    logic [IW-1:0] idx_last;
    logic [IW-1:0] idx_inc;
    logic [15:0]   cnt;
    logic          inf;

    logic hdr_acc;
    logic beat_acc;
    logic last_beat;
    logic load_abort;
    logic end_run;
    logic halt_hit;

    assign hdr_cmd   = s_data[31:30];
    assign hdr_start = s_data[29:16];
    assign hdr_cnt   = s_data[15:0];

    // Start index folded into the memory; out-of-range starts are flagged
    assign pm_start = IW'(32'(hdr_start) % PM_DEPTH);
    assign dm_start = IW'(32'(hdr_start) % DM_DEPTH);
    assign pm_oob   = 32'(hdr_start) >= PM_DEPTH;
    assign dm_oob   = 32'(hdr_start) >= DM_DEPTH;

    // Index advance, wrapping at the depth of the memory being loaded
    always_comb begin
        idx_last = (state == LOAD_DM) ? IW'(DM_DEPTH - 1)
                                      : IW'(PM_DEPTH - 1);
        idx_inc  = (idx == idx_last) ? '0 : idx + 1'b1;
    end

    assign s_ready  = (state != RUN);
    assign running  = (state == RUN);
    assign cpu_rstn = running;
    assign busy     = (state != IDLE);

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_n;
    end

    // Next-state and handshake decode
    always_comb begin
        state_n    = state;
        hdr_acc    = 1'b0;
        beat_acc   = 1'b0;
        last_beat  = 1'b0;
        load_abort = 1'b0;
        end_run    = 1'b0;
        unique case (state)
            IDLE: begin
                hdr_acc = s_valid;
                if (s_valid) begin
                    unique case (hdr_cmd)
                        2'b00: if (hdr_cnt != '0) state_n = LOAD_PM;
                        2'b01: if (hdr_cnt != '0) state_n = LOAD_DM;
                        2'b10: state_n = RUN;
                        default: state_n = IDLE;
                    endcase
                end
            end
            LOAD_PM, LOAD_DM: begin
                beat_acc   = s_valid;
                last_beat  = s_valid && (cnt == 16'd1);
                load_abort = stop_req && !last_beat;
                if (last_beat || load_abort) state_n = IDLE;
            end
            RUN: begin
                end_run = (!inf && cnt == 16'd1) || halt_hit || stop_req;
                if (end_run) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Beat/budget counter, load index, error flag and done pulse
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt   <= '0;
            inf   <= 1'b0;
            idx   <= '0;
            error <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= end_run;
            if (hdr_acc) begin
                cnt <= hdr_cnt;
                inf <= (hdr_cnt == '0);
                unique case (hdr_cmd)
                    2'b00: begin
                        idx   <= pm_start;
                        error <= pm_oob;
                    end
                    2'b01: begin
                        idx   <= dm_start;
                        error <= dm_oob;
                    end
                    2'b10:   error <= 1'b0;
                    default: error <= 1'b1;
                endcase
            end else if (beat_acc) begin
                cnt <= cnt - 16'd1;
                idx <= idx_inc;
            end else if (state == RUN && !inf) begin
                cnt <= cnt - 16'd1;
            end
            if (load_abort) error <= 1'b1;
        end
    end

    // Registered memory write ports; address/data hold between pulses
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pm_write_en           <= 1'b0;
            pm_write_address      <= '0;
            pm_data_in            <= '0;
            dm_write_en           <= 1'b0;
            dm_write_address_load <= '0;
            dm_data_in_load       <= '0;
        end else begin
            pm_write_en <= beat_acc && (state == LOAD_PM);
            dm_write_en <= beat_acc && (state == LOAD_DM);
            if (beat_acc && state == LOAD_PM) begin
                pm_write_address <= {idx[PAW-1:0], 2'b00};
                pm_data_in       <= s_data;
            end
            if (beat_acc && state == LOAD_DM) begin
                dm_write_address_load <= idx[DAW-1:0];
                dm_data_in_load       <= s_data;
            end
        end
    end

`ifdef HALT_DETECT_EN
    logic [BITS-1:0] pc_d1;
    logic [BITS-1:0] pc_d2;
    logic [1:0]      hist;

    // Only pc samples taken inside the current run count toward a halt
    assign halt_hit = (state == RUN) && (hist == 2'd2)
                   && (pc == pc_d1) && (pc == pc_d2);

    // pc history and sticky halted flag
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_d1  <= '0;
            pc_d2  <= '0;
            hist   <= '0;
            halted <= 1'b0;
        end else begin
            pc_d1 <= pc;
            pc_d2 <= pc_d1;
            if (hdr_acc) hist <= '0;
            else if (state == RUN && hist != 2'd2) hist <= hist + 2'd1;
            if (hdr_acc && hdr_cmd == 2'b10) halted <= 1'b0;
            else if (halt_hit) halted <= 1'b1;
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^pc;
    assign halt_hit  = 1'b0;
    assign halted    = 1'b0;
`endif

endmodule
